// File: rtl/rom_load_controller.sv
// Boot sequencer and arbiter for the shared program memory: loader writes, settle hold, then pipelined CPU reads.
// Writes land on the memory 1 cycle after the strobe; reads return N+1+MEM_LATENCY; no stalls, reads flushed on leaving RUN.
module rom_load_controller #(
    parameter int         ADDR_W        = 15,
    parameter int         MEM_LATENCY   = 1,
    parameter int         SETTLE_CYCLES = 256,
    parameter logic [7:0] FILL_BYTE     = 8'hFF
) (
    input  logic              clk_74a,
    input  logic              reset_n,
    input  logic              load_active,
    input  logic              ldr_write_en,
    input  logic [ADDR_W-1:0] ldr_write_addr,
    input  logic [7:0]        ldr_write_data,
    input  logic              cpu_rd_req,
    input  logic [ADDR_W-1:0] cpu_rd_addr,
    output logic              cpu_rd_ready,
    output logic              cpu_rd_valid,
    output logic [7:0]        cpu_rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    output logic              cpu_reset_n,
    output logic              load_done,
    output logic [ADDR_W:0]   loaded_bytes,
    output logic              load_error
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOADING, ST_SETTLE, ST_RUN} state_t;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t                 state;
    state_t                 next_state;
    logic                   load_active_q;
    logic [CNT_W-1:0]       settle_cnt;
    logic [ADDR_W-1:0]      hw;
    logic                   hw_valid;
    logic                   rd_fill;
    logic [MEM_LATENCY-1:0] vld_pipe;
    logic [MEM_LATENCY-1:0] fill_pipe;

    logic reload;
    logic settle_done;
    logic wr_fire;
    logic stray_wr;
    logic enter_load;
    logic leave_run;
    logic rd_fire;
    logic empty_load;

    // A new ROM is signalled by load_active rising, or by a write arriving while it is high.
    assign reload      = (load_active && !load_active_q) || (ldr_write_en && load_active);
    assign settle_done = (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (load_active || ldr_write_en) next_state = ST_LOADING;
            end
            ST_LOADING: begin
                if (!load_active) next_state = hw_valid ? ST_SETTLE : ST_IDLE;
            end
            ST_SETTLE: begin
                if (reload)           next_state = ST_LOADING;
                else if (settle_done) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (reload) next_state = ST_LOADING;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_rd_ready = (state == ST_RUN);
        load_done    = (state == ST_RUN);
    end

    assign wr_fire    = ldr_write_en && (state == ST_IDLE || state == ST_LOADING || load_active);
    assign stray_wr   = ldr_write_en && !load_active && (state == ST_SETTLE || state == ST_RUN);
    assign enter_load = (next_state == ST_LOADING) && (state != ST_LOADING);
    assign leave_run  = (state == ST_RUN) && (next_state != ST_RUN);
    // A request in the cycle RUN is left is dropped, so a reload write never collides with a read.
    assign rd_fire    = cpu_rd_req && (state == ST_RUN) && (next_state == ST_RUN);
    assign empty_load = (state == ST_LOADING) && !load_active && !hw_valid;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            load_active_q <= 1'b0;
            settle_cnt    <= '0;
            cpu_reset_n   <= 1'b0;
            hw            <= '0;
            hw_valid      <= 1'b0;
            load_error    <= 1'b0;
        end else begin
            load_active_q <= load_active;
            settle_cnt    <= (state == ST_SETTLE && next_state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
            cpu_reset_n   <= (next_state == ST_RUN);
            if (wr_fire) begin
                if (!hw_valid || enter_load || ldr_write_addr > hw) hw <= ldr_write_addr;
                hw_valid <= 1'b1;
            end else if (enter_load) begin
                hw       <= '0;
                hw_valid <= 1'b0;
            end
            if (enter_load)                   load_error <= 1'b0;
            else if (empty_load || stray_wr)  load_error <= 1'b1;
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            mem_rd_en   <= 1'b0;
            rd_fill     <= 1'b0;
        end else begin
            mem_wr_en <= wr_fire;
            mem_rd_en <= rd_fire;
            if (wr_fire) begin
                mem_addr    <= ldr_write_addr;
                mem_wr_data <= ldr_write_data;
            end else if (rd_fire) begin
                mem_addr <= cpu_rd_addr;
                rd_fill  <= (cpu_rd_addr > hw);
            end
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe  <= '0;
            fill_pipe <= '0;
        end else begin
            fill_pipe[0] <= rd_fill;
            for (int i = 1; i < MEM_LATENCY; i++) fill_pipe[i] <= fill_pipe[i-1];
            if (leave_run) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[0] <= mem_rd_en;
                for (int i = 1; i < MEM_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign cpu_rd_valid = vld_pipe[MEM_LATENCY-1];
    assign cpu_rd_data  = !cpu_rd_valid ? 8'h00 :
                          fill_pipe[MEM_LATENCY-1] ? FILL_BYTE : mem_rd_data;
    assign loaded_bytes = hw_valid ? ({1'b0, hw} + (ADDR_W+1)'(1)) : '0;

endmodule

// File: tb/tb_rom_load_controller.sv
// Randomized bench for rom_load_controller with a byte-array memory model and a timestamped read scoreboard.
module tb_rom_load_controller;
    localparam int         ADDR_W = 15;
    localparam int         LAT    = 1;
    localparam int         SETTLE = 256;
    localparam logic [7:0] FILL   = 8'hFF;
    localparam int         DEPTH  = 2 ** ADDR_W;

    logic              clk_74a = 1'b0;
    logic              reset_n = 1'b0;
    logic              load_active = 1'b0;
    logic              ldr_write_en = 1'b0;
    logic [ADDR_W-1:0] ldr_write_addr = '0;
    logic [7:0]        ldr_write_data = '0;
    logic              cpu_rd_req = 1'b0;
    logic [ADDR_W-1:0] cpu_rd_addr = '0;
    logic              cpu_rd_ready, cpu_rd_valid;
    logic [7:0]        cpu_rd_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en, mem_rd_en;
    logic [7:0]        mem_wr_data;
    logic [7:0]        mem_rd_data = '0;
    logic              cpu_reset_n, load_done, load_error;
    logic [ADDR_W:0]   loaded_bytes;

    rom_load_controller #(
        .ADDR_W(ADDR_W), .MEM_LATENCY(LAT), .SETTLE_CYCLES(SETTLE), .FILL_BYTE(FILL)
    ) dut (
        .clk_74a(clk_74a), .reset_n(reset_n), .load_active(load_active),
        .ldr_write_en(ldr_write_en), .ldr_write_addr(ldr_write_addr), .ldr_write_data(ldr_write_data),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_ready(cpu_rd_ready),
        .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data), .mem_addr(mem_addr),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_rd_en(mem_rd_en),
        .mem_rd_data(mem_rd_data), .cpu_reset_n(cpu_reset_n), .load_done(load_done),
        .loaded_bytes(loaded_bytes), .load_error(load_error)
    );

    always #5 clk_74a = ~clk_74a;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 0;

    always @(posedge clk_74a) cyc <= cyc + 1;

    // Synchronous RAM model with one cycle of read latency.
    logic [7:0] tb_mem [0:DEPTH-1];
    bit mem_ready = 0;
    always @(posedge clk_74a) begin
        if (!mem_ready) begin
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= 8'(i * 7 + 3);
            mem_ready <= 1;
        end else begin
            if (mem_wr_en) tb_mem[mem_addr] <= mem_wr_data;
            if (mem_rd_en) mem_rd_data <= tb_mem[mem_addr];
        end
    end

    logic [7:0] ref_mem [0:DEPTH-1];
    int ref_hw  = 0;
    bit ref_hwv = 0;

    typedef struct { int due; logic [7:0] dat; } rd_exp_t;
    rd_exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_rd(input int a);
        return (ref_hwv && a <= ref_hw) ? ref_mem[a] : FILL;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_74a);
            @(negedge clk_74a);
        end
    endtask

    // Every cycle: a read response appears exactly when one is due, with the expected byte.
    always @(negedge clk_74a) begin
        bit ev;
        if (mon_en) begin
            ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("rd_vld", cpu_rd_valid, ev);
            if (ev) begin
                if (cpu_rd_valid) chk("rd_dat", cpu_rd_data, exp_q[0].dat);
                void'(exp_q.pop_front());
            end
            chk("wr_rd_excl", mem_wr_en & mem_rd_en, 0);
        end
    end

    task automatic chk_reset_vals(input string p);
        chk({p, "_cpu_reset_n"}, cpu_reset_n, 0);
        chk({p, "_load_done"}, load_done, 0);
        chk({p, "_loaded_bytes"}, loaded_bytes, 0);
        chk({p, "_load_error"}, load_error, 0);
        chk({p, "_rd_ready"}, cpu_rd_ready, 0);
        chk({p, "_rd_valid"}, cpu_rd_valid, 0);
        chk({p, "_rd_data"}, cpu_rd_data, 0);
        chk({p, "_mem_wr_en"}, mem_wr_en, 0);
        chk({p, "_mem_rd_en"}, mem_rd_en, 0);
        chk({p, "_mem_addr"}, mem_addr, 0);
        chk({p, "_mem_wr_data"}, mem_wr_data, 0);
    endtask

    // Streams len bytes (sequential from 0, or random below span) with random gaps, then drops load_active.
    task automatic load_rom(input int len, input int span, input bit seq);
        load_active = 1;
        ref_hwv = 0;
        tick();
        for (int i = 0; i < len; i++) begin
            int a;
            logic [7:0] d;
            if ($urandom_range(3) == 0) begin
                ldr_write_en = 0;
                tick();
                chk("wr_gap", mem_wr_en, 0);
            end
            a = seq ? i : int'($urandom_range(span - 1));
            d = 8'($urandom);
            ldr_write_en = 1; ldr_write_addr = ADDR_W'(a); ldr_write_data = d;
            ref_mem[a] = d;
            if (!ref_hwv || a > ref_hw) ref_hw = a;
            ref_hwv = 1;
            tick();
            chk("wr_en", mem_wr_en, 1);
            chk("wr_addr", mem_addr, a);
            chk("wr_dat", mem_wr_data, d);
        end
        ldr_write_en = 0;
        tick();
        load_active = 0;
    endtask

    // Counts how long cpu_reset_n stays low once the load has ended, then checks RUN outputs.
    task automatic wait_run(input bit exp_err);
        int n;
        tick();
        chk("settle_rst", cpu_reset_n, 0);
        n = 0;
        while (!cpu_reset_n && n < 2000) begin
            chk("settle_done_lo", load_done, 0);
            n++;
            tick();
        end
        chk("settle_len", n, SETTLE);
        chk("run_done", load_done, 1);
        chk("run_ready", cpu_rd_ready, 1);
        chk("run_bytes", loaded_bytes, ref_hw + 1);
        chk("run_err", load_error, exp_err);
    endtask

    task automatic rd(input int a);
        cpu_rd_req = 1; cpu_rd_addr = ADDR_W'(a);
        exp_q.push_back('{cyc + 2, ref_rd(a)});
        tick();
    endtask

    task automatic rd_drain();
        cpu_rd_req = 0;
        tick(LAT + 3);
        chk("rd_drain", exp_q.size(), 0);
    endtask

    task automatic read_burst(input int n, input int amax);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(9) < 7) begin
                rd(int'($urandom_range(amax)));
            end else begin
                cpu_rd_req = 0;
                tick();
            end
        end
        rd_drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 7 + 3);
        #12;
        chk_reset_vals("rst");
        tick(3);
        reset_n = 1;
        mon_en = 1;
        tick(2);
        chk("idle_rst", cpu_reset_n, 0);

        // T1: 256-byte sequential image, settle hold, RUN
        load_rom(256, 256, 1);
        wait_run(0);
        chk("t1_bytes", loaded_bytes, 256);

        // T2: back-to-back reads incl. one above the image, then random traffic
        rd(16'h0010);
        rd(16'h0011);
        rd(16'h0200);
        rd_drain();
        read_burst(80, 16'h03FF);

        // T5: stray write in RUN is dropped and flagged
        begin
            logic [7:0] keep;
            keep = ref_mem[8'h20];
            ldr_write_en = 1; ldr_write_addr = ADDR_W'(8'h20); ldr_write_data = ~keep;
            tick();
            ldr_write_en = 0;
            chk("t5_no_wr", mem_wr_en, 0);
            chk("t5_err", load_error, 1);
            chk("t5_run", load_done, 1);
            chk("t5_cpu_rst", cpu_reset_n, 1);
            rd(8'h20);
            rd_drain();
        end

        // T3: reload while reads are in flight; nothing is returned for them
        cpu_rd_req = 1; cpu_rd_addr = ADDR_W'($urandom_range(255));
        tick();
        cpu_rd_req = 1; cpu_rd_addr = ADDR_W'($urandom_range(255));
        load_active = 1;
        tick();
        cpu_rd_req = 0;
        chk("t3_cpu_rst", cpu_reset_n, 0);
        chk("t3_ready", cpu_rd_ready, 0);
        chk("t3_done", load_done, 0);
        chk("t3_no_rd", mem_rd_en, 0);
        chk("t3_err_clr", load_error, 0);
        chk("t3_bytes", loaded_bytes, 0);
        tick(3);
        load_rom(40, 16'h0400, 0);
        wait_run(0);
        read_burst(120, ref_hw * 2 + 2);

        // T4: empty load returns to IDLE with an error, CPU stays in reset
        load_active = 1;
        tick(3);
        load_active = 0;
        tick(2);
        ref_hwv = 0;
        chk("t4_err", load_error, 1);
        chk("t4_cpu_rst", cpu_reset_n, 0);
        chk("t4_bytes", loaded_bytes, 0);
        chk("t4_done", load_done, 0);
        tick(300);
        chk("t4_cpu_rst_hold", cpu_reset_n, 0);
        chk("t4_err_hold", load_error, 1);

        // T6: asynchronous reset in the middle of the settle period
        load_rom(16, 64, 1);
        tick(50);
        chk("t6_settle", cpu_reset_n, 0);
        #2 reset_n = 0;
        #1 chk_reset_vals("t6");
        @(negedge clk_74a);
        reset_n = 1;
        ref_hwv = 0;
        tick(300);
        chk("t6_idle", cpu_reset_n, 0);

        // Write-only boot at the top address: full-depth image size
        ldr_write_en = 1; ldr_write_addr = ADDR_W'(DEPTH - 1); ldr_write_data = 8'h3C;
        ref_mem[DEPTH - 1] = 8'h3C; ref_hw = DEPTH - 1; ref_hwv = 1;
        tick();
        ldr_write_en = 0;
        wait_run(0);
        chk("full_bytes", loaded_bytes, DEPTH);
        rd(DEPTH - 1);
        rd(0);
        rd(int'($urandom_range(DEPTH - 1)));
        rd_drain();

        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
